// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 single-bit mux.
// Optional forced release after MAX_HOLD cycles: define MUX_ARB_HOLD_LIMIT_EN.
module mux_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic [1:0] owner,
  output logic       preempt
);

  if ((2 ** CNT_W) <= MAX_HOLD || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad
    $error("mux_rr_arbiter: illegal MAX_HOLD/CNT_W");
  end

  typedef enum logic {IDLE, GRANT} state_t;

  state_t     state, state_n;
  logic [1:0] ptr, ptr_n;
  logic [1:0] owner_n, sel_n;
  logic [3:0] gnt_n;
  logic       valid_n;
  logic [1:0] win_idle, win_next, ptr_inc;

  // First asserted index at or after base, wrapping modulo 4.
  function automatic logic [1:0] pick(
    input logic [3:0] r,
    input logic [1:0] base
  );
    logic [1:0] idx;
    pick = base;
    for (int i = 3; i >= 0; i--) begin
      idx = base + 2'(i);
      if (r[idx]) pick = idx;
    end
  endfunction

  assign ptr_inc  = owner + 2'd1;
  assign win_idle = pick(req, ptr);
  assign win_next = pick(req, ptr_inc);

`ifdef MUX_ARB_HOLD_LIMIT_EN
  logic [CNT_W-1:0] hold_cnt, hold_cnt_n;
  logic             preempt_n;
`endif

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt;
    sel_n   = sel;
    valid_n = valid;
    owner_n = owner;
`ifdef MUX_ARB_HOLD_LIMIT_EN
    hold_cnt_n = hold_cnt;
    preempt_n  = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          gnt_n   = 4'b0001 << win_idle;
          owner_n = win_idle;
          sel_n   = {win_idle[0], win_idle[1]};
          valid_n = 1'b1;
`ifdef MUX_ARB_HOLD_LIMIT_EN
          hold_cnt_n = '0;
`endif
        end
      end
      GRANT: begin
        if (req[owner]) begin
`ifdef MUX_ARB_HOLD_LIMIT_EN
          // Owner sorts last from owner+1, so win_next is never the owner here.
          if (hold_cnt == CNT_W'(MAX_HOLD - 1) && |(req & ~gnt)) begin
            ptr_n      = ptr_inc;
            gnt_n      = 4'b0001 << win_next;
            owner_n    = win_next;
            sel_n      = {win_next[0], win_next[1]};
            preempt_n  = 1'b1;
            hold_cnt_n = '0;
          end else if (hold_cnt != CNT_W'(MAX_HOLD)) begin
            hold_cnt_n = hold_cnt + 1'b1;
          end
`endif
        end else begin
          ptr_n = ptr_inc;
          if (|req) begin
            gnt_n   = 4'b0001 << win_next;
            owner_n = win_next;
            sel_n   = {win_next[0], win_next[1]};
`ifdef MUX_ARB_HOLD_LIMIT_EN
            hold_cnt_n = '0;
`endif
          end else begin
            state_n = IDLE;
            gnt_n   = 4'b0000;
            valid_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= 2'd0;
      gnt   <= 4'b0000;
      sel   <= 2'b00;
      valid <= 1'b0;
      owner <= 2'd0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt   <= gnt_n;
      sel   <= sel_n;
      valid <= valid_n;
      owner <= owner_n;
    end
  end

`ifdef MUX_ARB_HOLD_LIMIT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
      preempt  <= 1'b0;
    end else begin
      hold_cnt <= hold_cnt_n;
      preempt  <= preempt_n;
    end
  end
`else
  assign preempt = 1'b0;
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter: directed req vectors,
// expected outputs queued by the driver and checked by a monitor.
module tb_mux_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       valid;
  logic [1:0] owner;
  logic       preempt;

  mux_rr_arbiter #(.MAX_HOLD(4), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .sel     (sel),
    .valid   (valid),
    .owner   (owner),
    .preempt (preempt)
  );

  typedef struct {
    string      name;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic [1:0] owner;
    logic       preempt;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   errors  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input exp_t e);
    vectors++;
    if (gnt !== e.gnt || sel !== e.sel || valid !== e.valid ||
        owner !== e.owner || preempt !== e.preempt) begin
      errors++;
      $display("FAIL %s: got gnt=%b sel=%b valid=%b owner=%0d preempt=%b, want gnt=%b sel=%b valid=%b owner=%0d preempt=%b",
               e.name, gnt, sel, valid, owner, preempt,
               e.gnt, e.sel, e.valid, e.owner, e.preempt);
    end
  endtask

  // Drive req on the falling edge; expect the state after the next rising edge.
  task automatic step(input string n, input logic [3:0] r,
                      input logic [3:0] g, input logic [1:0] s,
                      input logic v, input logic [1:0] o,
                      input logic p);
    exp_t e;
    @(negedge clk);
    req = r;
    e = '{n, g, s, v, o, p};
    q.push_back(e);
  endtask

  // Monitor: compare one queued expectation per cycle, plus one-hot safety.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL onehot: got gnt=%b, want at most one bit", gnt);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  initial begin
    exp_t e;
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    e = '{"reset_hold", 4'b0000, 2'b00, 1'b0, 2'd0, 1'b0};
    check(e);

    // Release with all requesting: index 0 first.
    @(negedge clk);
    rst_n = 1'b1;
    e = '{"rst_release", 4'b0001, 2'b00, 1'b1, 2'd0, 1'b0};
    q.push_back(e);

    // Round robin 0,1,2,3,0 with no idle bubble.
    step("rr0_h1", 4'b1111, 4'b0001, 2'b00, 1, 2'd0, 0);
    step("rr0_h2", 4'b1111, 4'b0001, 2'b00, 1, 2'd0, 0);
    step("rr1",    4'b1110, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("rr1_h1", 4'b1110, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("rr1_h2", 4'b1110, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("rr2",    4'b1100, 4'b0100, 2'b01, 1, 2'd2, 0);
    step("rr2_h1", 4'b1100, 4'b0100, 2'b01, 1, 2'd2, 0);
    step("rr2_h2", 4'b1100, 4'b0100, 2'b01, 1, 2'd2, 0);
    step("rr3",    4'b1000, 4'b1000, 2'b11, 1, 2'd3, 0);
    step("rr3_h1", 4'b1000, 4'b1000, 2'b11, 1, 2'd3, 0);
    step("rr3_h2", 4'b1000, 4'b1000, 2'b11, 1, 2'd3, 0);
    step("rr0b",   4'b0111, 4'b0001, 2'b00, 1, 2'd0, 0);
    step("idle0",  4'b0000, 4'b0000, 2'b00, 0, 2'd0, 0);

    // Single requester 2 (ptr=1).
    step("single", 4'b0100, 4'b0100, 2'b01, 1, 2'd2, 0);
    step("s_drop", 4'b0000, 4'b0000, 2'b01, 0, 2'd2, 0);

    // ptr=3 picks 1; release leaves ptr=2; then 0011 wraps to 0.
    step("p3_g1",  4'b0010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("p2_idl", 4'b0000, 4'b0000, 2'b10, 0, 2'd1, 0);
    step("wrap",   4'b0011, 4'b0001, 2'b00, 1, 2'd0, 0);
    step("hand1",  4'b0010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("skip1",  4'b0001, 4'b0001, 2'b00, 1, 2'd0, 0);
    step("ignore", 4'b0011, 4'b0001, 2'b00, 1, 2'd0, 0);
    step("hand1b", 4'b0010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("idle1",  4'b0000, 4'b0000, 2'b10, 0, 2'd1, 0);

    // ptr=2: 1000 goes to 3, then asynchronous reset mid-grant.
    step("g3",     4'b1000, 4'b1000, 2'b11, 1, 2'd3, 0);
    step("g3_h",   4'b1000, 4'b1000, 2'b11, 1, 2'd3, 0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    e = '{"async_rst", 4'b0000, 2'b00, 1'b0, 2'd0, 1'b0};
    check(e);
    // Released ptr is 0, so 0110 goes to 1 (a stale ptr=2 would give 2).
    @(negedge clk);
    rst_n = 1'b1;
    req   = 4'b0110;
    e = '{"ptr_rst", 4'b0010, 2'b10, 1'b1, 2'd1, 1'b0};
    q.push_back(e);
    step("idle2",  4'b0000, 4'b0000, 2'b10, 0, 2'd1, 0);

`ifdef MUX_ARB_HOLD_LIMIT_EN
    // ptr=2: owner 1 holds four cycles, then 3 preempts it.
    step("hl_g1",  4'b0010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("hl_h1",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("hl_h2",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("hl_h3",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("hl_pre", 4'b1010, 4'b1000, 2'b11, 1, 2'd3, 1);
    step("hl_h3b", 4'b1010, 4'b1000, 2'b11, 1, 2'd3, 0);
    step("hl_ret", 4'b0010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("hl_idl", 4'b0000, 4'b0000, 2'b10, 0, 2'd1, 0);
`else
    // No hold limit: owner 1 keeps the grant while 3 waits.
    step("nl_g1",  4'b0010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("nl_h1",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("nl_h2",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("nl_h3",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("nl_h4",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("nl_h5",  4'b1010, 4'b0010, 2'b10, 1, 2'd1, 0);
    step("nl_g3",  4'b1000, 4'b1000, 2'b11, 1, 2'd3, 0);
    step("nl_idl", 4'b0000, 4'b0000, 2'b11, 0, 2'd3, 0);
`endif

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
        @(negedge clk);
        budget++;
      end
      if (q.size() > 0) begin
        errors++;
        $display("FAIL drain: got %0d pending, want 0", q.size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
